// File: rtl/mio_responder.sv
// mio_responder: memory-mapped I/O responder for a simple CPU bus.
// Serves a word RAM, a 16-bit GPIO register, a switch input port and a
// free-running cycle counter. Each access completes with a one-cycle
// MIO_ready pulse. RAM accesses take RAM_WAIT extra cycles.
//
// state | meaning
// IDLE  | waiting for mem_req; latches the request on acceptance
// WAIT  | counting RAM wait cycles down to zero
// RESP  | MIO_ready high, read data valid; write commits on leaving
module mio_responder #(
  parameter int RAM_WAIT = 2,
  parameter int RAM_AW   = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_req,
  input  logic        mem_w,
  input  logic [31:0] M_addr,
  input  logic [31:0] data_out,
  output logic [31:0] data2CPU,
  output logic        MIO_ready,
  input  logic [15:0] sw_in,
  output logic [15:0] gpio_out,
  output logic        bus_err
);

  localparam int RAM_DEPTH = 1 << RAM_AW;
  localparam logic [3:0] WAIT_LOAD = (RAM_WAIT > 0) ? 4'(RAM_WAIT - 1) : 4'd0;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  typedef enum logic [2:0] {REG_RAM, REG_GPIO, REG_SW, REG_CNT, REG_BAD} region_t;

  state_t              state;
  region_t             region_q;
  logic [RAM_AW-1:0]   idx_q;
  logic [31:0]         wdata_q;
  logic                w_q;
  logic [3:0]          wait_cnt;
  logic [31:0]         counter;
  logic [31:0]         ram [0:RAM_DEPTH-1];

  region_t             src_region;
  logic [RAM_AW-1:0]   src_idx;
  logic                src_w;
  logic                go_resp;
  logic [31:0]         rd_val;

  // Misaligned addresses and writes to read-only registers are errors.
  function automatic region_t decode(input logic [31:0] a, input logic w);
    region_t r;
    r = REG_BAD;
    if (a[1:0] == 2'b00) begin
      if (a[31:RAM_AW+2] == '0)        r = REG_RAM;
      else if (a == 32'hE000_0000)     r = REG_GPIO;
      else if (a == 32'hF000_0000)     r = w ? REG_BAD : REG_SW;
      else if (a == 32'hF000_0004)     r = w ? REG_BAD : REG_CNT;
    end
    return r;
  endfunction

  // Peripheral accesses respond straight from IDLE, so the response source
  // is the live bus in IDLE and the latched request otherwise.
  always_comb begin
    src_region = region_q;
    src_idx    = idx_q;
    src_w      = w_q;
    if (state == IDLE) begin
      src_region = decode(M_addr, mem_w);
      src_idx    = M_addr[RAM_AW+1:2];
      src_w      = mem_w;
    end
    go_resp = 1'b0;
    if (state == IDLE && mem_req)
      go_resp = !(src_region == REG_RAM && RAM_WAIT > 0);
    else if (state == WAIT)
      go_resp = (wait_cnt == 4'd0);
    // counter + 1 is the value the counter holds during the RESP cycle
    case (src_region)
      REG_RAM:  rd_val = ram[src_idx];
      REG_GPIO: rd_val = {16'h0000, gpio_out};
      REG_SW:   rd_val = {16'h0000, sw_in};
      REG_CNT:  rd_val = counter + 32'd1;
      default:  rd_val = 32'h0000_0000;
    endcase
  end

  // Request sequencing, response generation and GPIO write commit.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      region_q  <= REG_BAD;
      idx_q     <= '0;
      wdata_q   <= '0;
      w_q       <= 1'b0;
      wait_cnt  <= 4'd0;
      MIO_ready <= 1'b0;
      data2CPU  <= 32'h0000_0000;
      gpio_out  <= 16'h0000;
      bus_err   <= 1'b0;
    end else begin
      MIO_ready <= 1'b0;
      case (state)
        IDLE: begin
          if (mem_req) begin
            region_q <= src_region;
            idx_q    <= M_addr[RAM_AW+1:2];
            wdata_q  <= data_out;
            w_q      <= mem_w;
            if (go_resp) begin
              state <= RESP;
            end else begin
              state    <= WAIT;
              wait_cnt <= WAIT_LOAD;
            end
          end
        end
        WAIT: begin
          if (wait_cnt == 4'd0) state <= RESP;
          else                  wait_cnt <= wait_cnt - 4'd1;
        end
        RESP: begin
          state <= IDLE;
          if (w_q && region_q == REG_GPIO) gpio_out <= wdata_q[15:0];
        end
        default: state <= IDLE;
      endcase
      if (go_resp) begin
        MIO_ready <= 1'b1;
        if (src_region == REG_BAD) bus_err <= 1'b1;
        if (!src_w) data2CPU <= rd_val;
      end
    end
  end

  // RAM write commit on the edge leaving RESP; contents survive reset.
  always_ff @(posedge clk) begin
    if (reset && state == RESP && w_q && region_q == REG_RAM)
      ram[idx_q] <= wdata_q;
  end

  // Free-running cycle counter.
  always_ff @(posedge clk) begin
    if (!reset) counter <= 32'h0000_0000;
    else        counter <= counter + 32'd1;
  end

endmodule

// File: tb/tb_mio_responder.sv
// Testbench for mio_responder: directed transactions against a
// transaction-level model of the address map and response timing.
module tb_mio_responder;
  localparam int RW = 2;
  localparam int AW = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        mem_req = 1'b0;
  logic        mem_w = 1'b0;
  logic [31:0] M_addr = '0;
  logic [31:0] data_out = '0;
  logic [15:0] sw_in = 16'h00F0;
  logic [31:0] data2CPU;
  logic        MIO_ready;
  logic [15:0] gpio_out;
  logic        bus_err;

  mio_responder #(.RAM_WAIT(RW), .RAM_AW(AW)) dut (
    .clk(clk), .reset(reset), .mem_req(mem_req), .mem_w(mem_w),
    .M_addr(M_addr), .data_out(data_out), .data2CPU(data2CPU),
    .MIO_ready(MIO_ready), .sw_in(sw_in), .gpio_out(gpio_out),
    .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // 0 ram, 1 gpio, 2 switch, 3 counter, 4 unmapped/misaligned
  function automatic int kind(input logic [31:0] a);
    if (a[1:0] != 2'b00) return 4;
    if (a < 32'(4 * (1 << AW))) return 0;
    if (a == 32'hE000_0000) return 1;
    if (a == 32'hF000_0000) return 2;
    if (a == 32'hF000_0004) return 3;
    return 4;
  endfunction

  function automatic bit is_err(input logic [31:0] a, input logic w);
    int k;
    k = kind(a);
    return (k == 4) || (w && (k == 2 || k == 3));
  endfunction

  function automatic int extra(input logic [31:0] a);
    return (kind(a) == 0) ? RW : 0;
  endfunction

  // model state
  int          cyc = 0;
  logic [31:0] m_cnt = '0;
  logic [31:0] m_data = '0;
  logic [15:0] m_gpio = '0;
  logic        m_err = 1'b0;
  logic        exp_ready = 1'b0;
  logic [31:0] mram [0:(1<<AW)-1];
  bit          pend = 0;
  int          resp_cyc = 0;
  int          bb_left = 0;
  logic        p_w = 1'b0;
  logic [31:0] p_addr = '0;
  logic [31:0] p_data = '0;
  bit          commit = 0;
  logic [31:0] c_addr = '0;
  logic [31:0] c_data = '0;

  // Model: predicts outputs after each rising edge.
  always @(posedge clk) begin
    cyc++;
    if (!reset) begin
      m_cnt = '0; m_data = '0; m_gpio = '0; m_err = 1'b0;
      exp_ready = 1'b0; pend = 0; commit = 0; bb_left = 0;
    end else begin
      m_cnt++;
      exp_ready = 1'b0;
      if (commit) begin
        if (kind(c_addr) == 0) mram[c_addr[AW+1:2]] = c_data;
        else m_gpio = c_data[15:0];
        commit = 0;
      end
      if (pend && cyc == resp_cyc) begin
        exp_ready = 1'b1;
        if (is_err(p_addr, p_w)) begin
          m_err = 1'b1;
          if (!p_w) m_data = '0;
        end else if (p_w) begin
          commit = 1; c_addr = p_addr; c_data = p_data;
        end else begin
          case (kind(p_addr))
            0: m_data = mram[p_addr[AW+1:2]];
            1: m_data = {16'h0000, m_gpio};
            2: m_data = {16'h0000, sw_in};
            default: m_data = m_cnt;
          endcase
        end
        if (bb_left > 0) begin
          bb_left--;
          resp_cyc = cyc + 2 + extra(p_addr);
        end else begin
          pend = 0;
        end
      end
    end
  end

  bit   chk_en = 0;
  logic prev_ready = 1'b0;

  // Compare DUT against model every cycle, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("MIO_ready", {31'b0, MIO_ready}, {31'b0, exp_ready});
      check("data2CPU", data2CPU, m_data);
      check("gpio_out", {16'h0, gpio_out}, {16'h0, m_gpio});
      check("bus_err", {31'b0, bus_err}, {31'b0, m_err});
      n_cmp++;
      if (prev_ready && MIO_ready) begin
        n_bad++;
        $display("FAIL ready_consecutive: got 1 in two cycles expected a low cycle between");
      end
      prev_ready = MIO_ready;
    end
  end

  task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d, input int bb);
    mem_req = 1'b1; mem_w = w; M_addr = a; data_out = d;
    p_w = w; p_addr = a; p_data = d;
    resp_cyc = cyc + 1 + extra(a);
    bb_left = bb;
    pend = 1;
  endtask

  task automatic txn(input logic w, input logic [31:0] a, input logic [31:0] d,
                     input int exp_lat, input string name);
    int n;
    @(negedge clk);
    issue(w, a, d, 0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!MIO_ready && n < 40);
    mem_req = 1'b0;
    check({name, " latency"}, 32'(n), 32'(exp_lat));
  endtask

  task automatic b2b(input logic [31:0] a, input int count, input string name);
    int pulses;
    @(negedge clk);
    issue(1'b0, a, '0, count - 1);
    pulses = 0;
    for (int i = 0; i < 60 && pulses < count; i++) begin
      @(negedge clk);
      if (MIO_ready) pulses++;
    end
    mem_req = 1'b0;
    check({name, " pulses"}, 32'(pulses), 32'(count));
  endtask

  logic [31:0] c1, c2;

  initial begin
    @(negedge clk);
    chk_en = 1;
    check("rst MIO_ready", {31'b0, MIO_ready}, 32'd0);
    check("rst data2CPU", data2CPU, 32'h0);
    check("rst gpio_out", {16'h0, gpio_out}, 32'h0);
    check("rst bus_err", {31'b0, bus_err}, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    txn(1'b1, 32'h10, 32'hDEAD_BEEF, 3, "ram_wr");
    txn(1'b0, 32'h10, 32'h0, 3, "ram_rd");
    check("ram_rd data", data2CPU, 32'hDEAD_BEEF);

    txn(1'b1, 32'hE000_0000, 32'h1234_ABCD, 1, "gpio_wr");
    @(negedge clk);
    check("gpio_out value", {16'h0, gpio_out}, 32'h0000_ABCD);
    txn(1'b0, 32'hE000_0000, 32'h0, 1, "gpio_rd");
    check("gpio_rd data", data2CPU, 32'h0000_ABCD);

    txn(1'b0, 32'hF000_0000, 32'h0, 1, "sw_rd");
    check("sw_rd data", data2CPU, 32'h0000_00F0);

    txn(1'b0, 32'hF000_0004, 32'h0, 1, "cnt_rd1");
    c1 = data2CPU;
    repeat (5) @(negedge clk);
    txn(1'b0, 32'hF000_0004, 32'h0, 1, "cnt_rd2");
    c2 = data2CPU;
    check("cnt diff", c2 - c1, 32'd7);

    txn(1'b1, 32'h0, 32'h1111_1111, 3, "ram0_wr");
    check("bus_err clean", {31'b0, bus_err}, 32'd0);
    txn(1'b0, 32'h8000_0000, 32'h0, 1, "unmapped_rd");
    check("unmapped data", data2CPU, 32'h0);
    check("unmapped bus_err", {31'b0, bus_err}, 32'd1);
    txn(1'b1, 32'h0000_0002, 32'hCAFE_F00D, 1, "misaligned_wr");
    txn(1'b1, 32'hF000_0004, 32'h0000_0001, 1, "cnt_wr");
    txn(1'b0, 32'h0, 32'h0, 3, "ram0_rd");
    check("ram0 unchanged", data2CPU, 32'h1111_1111);
    check("bus_err sticky", {31'b0, bus_err}, 32'd1);

    b2b(32'hF000_0000, 4, "b2b_sw");
    b2b(32'h10, 3, "b2b_ram");

    txn(1'b1, 32'h20, 32'h0, 3, "ram20_zero");
    @(negedge clk);
    issue(1'b1, 32'h20, 32'h5555_5555, 0);
    @(negedge clk);
    reset = 1'b0;
    mem_req = 1'b0;
    @(negedge clk);
    check("abort MIO_ready", {31'b0, MIO_ready}, 32'd0);
    check("abort data2CPU", data2CPU, 32'h0);
    check("abort gpio_out", {16'h0, gpio_out}, 32'h0);
    check("abort bus_err", {31'b0, bus_err}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    txn(1'b0, 32'h20, 32'h0, 3, "ram20_rd");
    check("ram20 not written", data2CPU, 32'h0);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    n_bad++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "watchdog");
  end

endmodule
